// File: rtl/hazard_stall_ctrl_if.sv
// Interface between the ID/EX stages and the load-use hazard / pipeline-control unit.
// The HAZARD_PERF_CNT_EN macro adds the performance-counter outputs.
interface hazard_stall_ctrl_if #(
    parameter int REG_W = 5
`ifdef HAZARD_PERF_CNT_EN
    , parameter int PERF_W = 32
`endif
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             dmem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             pipe_freeze;
    logic             stall_active;
`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] perf_lu_events;
    logic [PERF_W-1:0] perf_stall_cycles;
`endif

    modport master (
`ifdef HAZARD_PERF_CNT_EN
        input  perf_lu_events, perf_stall_cycles,
`endif
        output id_rs, id_rt, id_rs_used, id_rt_used, ex_rd, ex_mem_read,
               ex_branch_taken, dmem_busy,
        input  pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze,
               stall_active
    );

    modport slave (
`ifdef HAZARD_PERF_CNT_EN
        output perf_lu_events, perf_stall_cycles,
`endif
        input  id_rs, id_rt, id_rs_used, id_rt_used, ex_rd, ex_mem_read,
               ex_branch_taken, dmem_busy,
        output pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze,
               stall_active
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use hazard detector with a registered multi-bubble stall sequencer, branch flush and
// data-memory freeze. Define HAZARD_PERF_CNT_EN to add saturating load-use perf counters.
module hazard_stall_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 4
`ifdef HAZARD_PERF_CNT_EN
    , parameter int PERF_W = 32
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_ctrl_if.slave  bus
);
    typedef enum logic {IDLE, LU_STALL} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stall_active;

    logic w_rs_hit, w_rt_hit, w_hz;
    logic w_freeze, w_flush, w_lu_stall, w_lu_entry;
    logic w_pc_write, w_if_id_write, w_id_ex_bubble, w_if_id_flush, w_pipe_freeze;

    assign w_rs_hit = bus.id_rs_used && (bus.id_rs == bus.ex_rd);
    assign w_rt_hit = bus.id_rt_used && (bus.id_rt == bus.ex_rd);
    assign w_hz     = bus.ex_mem_read && (bus.ex_rd != REG_W'(0)) && (w_rs_hit || w_rt_hit);

    // Priority chain: freeze > flush > ongoing stall > new hazard in IDLE.
    assign w_freeze   = bus.dmem_busy;
    assign w_flush    = !w_freeze && bus.ex_branch_taken;
    assign w_lu_stall = !w_freeze && !w_flush && (r_state == LU_STALL);
    assign w_lu_entry = !w_freeze && !w_flush && (r_state == IDLE) && w_hz;

    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_id_ex_bubble = 1'b0;
        w_if_id_flush  = 1'b0;
        w_pipe_freeze  = 1'b0;
        if (!rst_n) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
        end else if (w_freeze) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_pipe_freeze  = 1'b1;
        end else if (w_flush) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (w_lu_stall || w_lu_entry) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
        end
    end

    // Freeze cycles fall through every branch, so state and counter hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_stall_active <= 1'b0;
        end else if (w_flush) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_stall_active <= 1'b0;
        end else if (w_lu_stall) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_state        <= IDLE;
                r_stall_active <= 1'b0;
            end
        end else if (w_lu_entry && (LOAD_LAT > 1)) begin
            r_state        <= LU_STALL;
            r_cnt          <= CNT_W'(LOAD_LAT - 1);
            r_stall_active <= 1'b1;
        end
    end

    assign bus.pc_write     = w_pc_write;
    assign bus.if_id_write  = w_if_id_write;
    assign bus.id_ex_bubble = w_id_ex_bubble;
    assign bus.if_id_flush  = w_if_id_flush;
    assign bus.pipe_freeze  = w_pipe_freeze;
    assign bus.stall_active = r_stall_active;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_W-1:0] r_perf_lu_events;
    logic [PERF_W-1:0] r_perf_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_lu_events    <= '0;
            r_perf_stall_cycles <= '0;
        end else begin
            if (w_lu_entry && (r_perf_lu_events != '1))
                r_perf_lu_events <= r_perf_lu_events + PERF_W'(1);
            if ((w_lu_entry || w_lu_stall) && (r_perf_stall_cycles != '1))
                r_perf_stall_cycles <= r_perf_stall_cycles + PERF_W'(1);
        end
    end

    assign bus.perf_lu_events    = r_perf_lu_events;
    assign bus.perf_stall_cycles = r_perf_stall_cycles;
`endif
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: two controllers (LOAD_LAT=1 and 3) share stimulus; a remaining-bubble model
// predicts each cycle's outputs, and a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic       id_rs_used = 1'b0, id_rt_used = 1'b0, ex_mem_read = 1'b0;
    logic       ex_branch_taken = 1'b0, dmem_busy = 1'b0;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.REG_W(5)) bus1 ();
    hazard_stall_ctrl_if #(.REG_W(5)) bus3 ();

    assign bus1.id_rs = id_rs;           assign bus3.id_rs = id_rs;
    assign bus1.id_rt = id_rt;           assign bus3.id_rt = id_rt;
    assign bus1.id_rs_used = id_rs_used; assign bus3.id_rs_used = id_rs_used;
    assign bus1.id_rt_used = id_rt_used; assign bus3.id_rt_used = id_rt_used;
    assign bus1.ex_rd = ex_rd;           assign bus3.ex_rd = ex_rd;
    assign bus1.ex_mem_read = ex_mem_read;         assign bus3.ex_mem_read = ex_mem_read;
    assign bus1.ex_branch_taken = ex_branch_taken; assign bus3.ex_branch_taken = ex_branch_taken;
    assign bus1.dmem_busy = dmem_busy;   assign bus3.dmem_busy = dmem_busy;

    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );
    hazard_stall_ctrl #(.REG_W(5), .LOAD_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3)
    );

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, pipe_freeze, stall_active}
    logic [5:0] got1, got3;
    assign got1 = {bus1.pc_write, bus1.if_id_write, bus1.id_ex_bubble,
                   bus1.if_id_flush, bus1.pipe_freeze, bus1.stall_active};
    assign got3 = {bus3.pc_write, bus3.if_id_write, bus3.id_ex_bubble,
                   bus3.if_id_flush, bus3.pipe_freeze, bus3.stall_active};

    typedef struct packed {
        int         id;
        logic [5:0] e1;
        logic [5:0] e3;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   txn    = 0;
    int   rem1   = 0;
    int   rem3   = 0;
    int   perf_lu3 = 0;
    int   perf_st3 = 0;

    // Reference: rem = bubbles still owed after this cycle's one.
    function automatic logic [5:0] model_out(input int rem, input bit in_rst, input bit busy,
                                             input bit br, input bit hz);
        logic sa;
        sa = (rem > 0);
        if (in_rst)          return 6'b001000;
        if (busy)            return {5'b00001, sa};
        if (br)              return {5'b11110, sa};
        if (rem > 0 || hz)   return {5'b00100, sa};
        return {5'b11000, sa};
    endfunction

    function automatic int model_next(input int rem, input bit in_rst, input bit busy,
                                      input bit br, input bit hz, input int lat);
        if (in_rst)  return 0;
        if (busy)    return rem;
        if (br)      return 0;
        if (rem > 0) return rem - 1;
        if (hz)      return lat - 1;
        return 0;
    endfunction

    task automatic step(input bit rst, input bit mr, input int rd, input int rs, input bit rsu,
                        input int rt, input bit rtu, input bit br, input bit busy);
        exp_t e;
        bit   hz;
        @(posedge clk);
        #1;
        rst_n = !rst;
        ex_mem_read = mr;  ex_rd = 5'(rd);
        id_rs = 5'(rs);    id_rs_used = rsu;
        id_rt = 5'(rt);    id_rt_used = rtu;
        ex_branch_taken = br;
        dmem_busy = busy;
        hz = mr && (rd != 0) && ((rsu && rs == rd) || (rtu && rt == rd));
        e.id = txn;
        e.e1 = model_out(rem1, rst, busy, br, hz);
        e.e3 = model_out(rem3, rst, busy, br, hz);
        sb.push_back(e);
        if (rst) begin
            perf_lu3 = 0;
            perf_st3 = 0;
        end else if (!busy && !br) begin
            if (rem3 == 0 && hz) perf_lu3++;
            if (rem3 > 0 || hz)  perf_st3++;
        end
        rem1 = model_next(rem1, rst, busy, br, hz, 1);
        rem3 = model_next(rem3, rst, busy, br, hz, 3);
        txn++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: the DUT presents outputs every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks += 2;
                if (got1 === e.e1) passed++;
                else $display("FAIL txn%0d lat1_outputs got=%b want=%b", e.id, got1, e.e1);
                if (got3 === e.e3) passed++;
                else $display("FAIL txn%0d lat3_outputs got=%b want=%b", e.id, got3, e.e3);
                $display("txn %0d rst_n=%b lat1=%b/%b lat3=%b/%b", e.id, rst_n,
                         got1, e.e1, got3, e.e3);
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 3, 3, 1, 0, 0, 0, 0);
        idle(2);
        // single load-use hazard on rs
        step(0, 1, 3, 3, 1, 0, 0, 0, 0);
        idle(4);
        // hazard on rt
        step(0, 1, 7, 1, 1, 7, 1, 0, 0);
        idle(4);
        // register zero and unused operand never hazard
        step(0, 1, 0, 0, 1, 0, 1, 0, 0);
        step(0, 1, 5, 2, 1, 5, 0, 0, 0);
        idle(1);
        // freeze in the middle of a stall
        step(0, 1, 3, 3, 1, 0, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        // taken branch coincident with a hazard
        step(0, 1, 3, 3, 1, 0, 0, 1, 0);
        idle(3);
        // branch arriving during busy, then honoured
        step(0, 1, 4, 4, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        // reset in the middle of a stall
        step(0, 1, 3, 3, 1, 0, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end
        idle(6);
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
`ifdef HAZARD_PERF_CNT_EN
        checks += 2;
        if (bus3.perf_lu_events == 32'(perf_lu3)) passed++;
        else $display("FAIL perf_lu_events got=%0d want=%0d", bus3.perf_lu_events, perf_lu3);
        if (bus3.perf_stall_cycles == 32'(perf_st3)) passed++;
        else $display("FAIL perf_stall_cycles got=%0d want=%0d", bus3.perf_stall_cycles, perf_st3);
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
